fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- IF stage of the hardware-scheduled pipeline: owns the PC register, drives the instruction-memory address, and registers the IF/ID pipeline latch.
- Consumes the stall/flush pair produced by ID-stage hazard detection, plus the redirect target from branch/jump resolution.
- Keeps saturating stall/flush event counters for performance debug.

Parameters:
- ADDR_W, 32, PC / instruction-memory address width.
- INSTR_W, 32, instruction width.
- RESET_PC, 32'h0040_0000, PC value loaded on reset.
- CNT_W, 16, width of each performance counter.

Ports:
- i_CLK  input  1  clock; all state updates on the rising edge.
- i_RST_N  input  1  reset; asynchronous, active-low.
- stall  input  1  hold PC and IF/ID (load-use hazard).
- flush  input  1  redirect fetch and squash the IF/ID contents.
- redirect_pc  input  ADDR_W  target PC, sampled only when flush is applied.
- imem_rdy  input  1  instruction memory returns valid data this cycle.
- imem_instr  input  INSTR_W  instruction read at imem_addr, same cycle.
- imem_addr  output  ADDR_W  current PC (combinational from PC register).
- ifid_instr  output  INSTR_W  registered instruction.
- ifid_pc4  output  ADDR_W  registered PC+4 of ifid_instr.
- ifid_valid  output  1  IF/ID holds a real instruction (0 = bubble).
- stall_cnt  output  CNT_W  cycles in which stall was applied.
- flush_cnt  output  CNT_W  cycles in which flush was applied.

Behaviour:
- Reset (i_RST_N low, async): PC=RESET_PC; ifid_instr=0 (NOP); ifid_pc4=0; ifid_valid=0; both counters 0. Outputs hold these values while reset is held. On deassertion, the first edge fetches RESET_PC.
- imem_addr = PC, with bits [1:0] always 0.
- Per-edge priority, evaluated in order (exactly one action per edge):
  1. stall=1: PC, ifid_* hold; flush is ignored in this cycle (branch operands are stale; ID re-evaluates next cycle); stall_cnt++.
  2. flush=1: PC <= {redirect_pc[ADDR_W-1:2], 2'b00}; ifid_instr <= 0; ifid_valid <= 0; ifid_pc4 <= 0; flush_cnt++. Applies regardless of imem_rdy.
  3. imem_rdy=0: PC holds; IF/ID <= bubble (instr 0, valid 0, pc4 0).
  4. Otherwise: ifid_instr <= imem_instr; ifid_pc4 <= PC+4; ifid_valid <= 1; PC <= PC+4.
- Latency: an instruction at address A appears on ifid_* one edge after the cycle in which imem_addr=A and imem_rdy=1 with no stall/flush.
- A flush costs exactly one bubble in IF/ID. The redirected instruction is latched on the following non-stalled, ready edge.
- PC+4 arithmetic is modulo 2^ADDR_W. PC=32'hFFFF_FFFC wraps to 0, with ifid_pc4=0.
- Counters saturate at all-ones and never wrap.
- Stall held N cycles: IF/ID remains bit-identical for all N cycles, including ifid_valid.
- Reset asserted mid-stall or mid-flush: immediate return to reset values; no pending redirect is retained.

Decomposition:
- Shared pipeline package: NOP_INSTR (32'h0000_0000), RESET_PC default, and the IF/ID bundle field widths, so the ID stage uses identical definitions.
- One sub-module: sat_counter (parameter CNT_W; inputs clk, rst_n, inc; output count), instantiated twice.
- The PC/IF/ID datapath stays in fetch_stage.

Test Plan:
- Reset release, imem_rdy=1, instructions 0x20080001/0x20090002 -> imem_addr 0x00400000 then 0x00400004; ifid_pc4 = 0x00400004 then 0x00400008; ifid_valid=1 from the first edge.
- stall=1 for 3 cycles while ifid_instr=0x8D280000 -> PC and ifid_* frozen; stall_cnt=3; on release, fetch resumes at the held PC.
- flush=1, redirect_pc=0x00400103 -> next PC=0x00400100; ifid_valid=0 and ifid_instr=0 for one cycle; the instruction at 0x00400100 is latched on the next edge; flush_cnt=1.
- stall=1 and flush=1 together with redirect_pc=0x00400200 -> stall wins: PC unchanged, flush_cnt unchanged, stall_cnt +1.
- imem_rdy=0 for 2 cycles -> two bubbles, PC held; then imem_rdy=1 gives a normal fetch. Separately, flush during imem_rdy=0 still redirects the PC.
- PC forced to 0xFFFFFFFC via redirect -> next PC=0, ifid_pc4=0. Separately, a counter driven 2^CNT_W+5 times reads 0xFFFF. i_RST_N pulsed low mid-stall -> all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Shared pipeline definitions for the IF stage and the ID stage that consumes
// the IF/ID latch, so both sides agree on reset PC, NOP encoding and widths.
package fetch_stage_pkg;

  localparam int unsigned IFID_ADDR_W  = 32;
  localparam int unsigned IFID_INSTR_W = 32;

  localparam logic [IFID_ADDR_W-1:0]  RESET_PC_DEFAULT = 32'h0040_0000;
  localparam logic [IFID_INSTR_W-1:0] NOP_INSTR        = 32'h0000_0000;

  localparam int unsigned CNT_W_DEFAULT = 16;

endpackage

// File: rtl/fetch_stage_sat_counter.sv
// Saturating event counter: increments on inc, sticks at all-ones, never wraps.
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] r_count;
  logic             w_full;

  assign w_full = &r_count;
  assign count  = r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (inc && !w_full) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, instruction-memory address, IF/ID latch,
// and saturating stall/flush counters for performance debug.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int unsigned         ADDR_W   = IFID_ADDR_W,
  parameter int unsigned         INSTR_W  = IFID_INSTR_W,
  parameter logic [ADDR_W-1:0]   RESET_PC = ADDR_W'(RESET_PC_DEFAULT),
  parameter int unsigned         CNT_W    = CNT_W_DEFAULT
) (
  input  logic               i_CLK,
  input  logic               i_RST_N,
  input  logic               stall,
  input  logic               flush,
  input  logic [ADDR_W-1:0]  redirect_pc,
  input  logic               imem_rdy,
  input  logic [INSTR_W-1:0] imem_instr,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic [INSTR_W-1:0] ifid_instr,
  output logic [ADDR_W-1:0]  ifid_pc4,
  output logic               ifid_valid,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   flush_cnt
);

  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

  logic [ADDR_W-1:0]  r_pc;
  logic [INSTR_W-1:0] r_ifid_instr;
  logic [ADDR_W-1:0]  r_ifid_pc4;
  logic               r_ifid_valid;
  logic [ADDR_W-1:0]  w_pc;
  logic [ADDR_W-1:0]  w_pc4;
  logic               w_flush_taken;

  assign w_pc          = r_pc & ALIGN_MASK;
  assign w_pc4         = w_pc + ADDR_W'(4);
  assign w_flush_taken = flush && !stall;

  assign imem_addr  = w_pc;
  assign ifid_instr = r_ifid_instr;
  assign ifid_pc4   = r_ifid_pc4;
  assign ifid_valid = r_ifid_valid;

  // imem handshake: imem_instr is the word at imem_addr and is only consumed on
  // an edge where imem_rdy=1 with no stall/flush; there is no request signal,
  // the memory is assumed to track imem_addr continuously.
  // Stall beats flush: with a load-use stall the branch operands are stale and
  // ID re-resolves the redirect next cycle.
  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      r_pc         <= RESET_PC;
      r_ifid_instr <= INSTR_W'(NOP_INSTR);
      r_ifid_pc4   <= '0;
      r_ifid_valid <= 1'b0;
    end else if (stall) begin
      r_pc         <= r_pc;
      r_ifid_instr <= r_ifid_instr;
      r_ifid_pc4   <= r_ifid_pc4;
      r_ifid_valid <= r_ifid_valid;
    end else if (flush) begin
      r_pc         <= redirect_pc & ALIGN_MASK;
      r_ifid_instr <= INSTR_W'(NOP_INSTR);
      r_ifid_pc4   <= '0;
      r_ifid_valid <= 1'b0;
    end else if (!imem_rdy) begin
      r_pc         <= r_pc;
      r_ifid_instr <= INSTR_W'(NOP_INSTR);
      r_ifid_pc4   <= '0;
      r_ifid_valid <= 1'b0;
    end else begin
      r_pc         <= w_pc4;
      r_ifid_instr <= imem_instr;
      r_ifid_pc4   <= w_pc4;
      r_ifid_valid <= 1'b1;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (i_CLK),
    .rst_n (i_RST_N),
    .inc   (stall),
    .count (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (i_CLK),
    .rst_n (i_RST_N),
    .inc   (w_flush_taken),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: hand-computed expectations checked with
// immediate assertions one edge at a time.
module tb_fetch_stage;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        flush;
  logic [31:0] redirect_pc;
  logic        imem_rdy;
  logic [31:0] imem_instr;
  logic [31:0] imem_addr;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc4;
  logic        ifid_valid;
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;

  int n_cmp = 0;
  int n_err = 0;

  fetch_stage dut (
    .i_CLK       (clk),
    .i_RST_N     (rst_n),
    .stall       (stall),
    .flush       (flush),
    .redirect_pc (redirect_pc),
    .imem_rdy    (imem_rdy),
    .imem_instr  (imem_instr),
    .imem_addr   (imem_addr),
    .ifid_instr  (ifid_instr),
    .ifid_pc4    (ifid_pc4),
    .ifid_valid  (ifid_valid),
    .stall_cnt   (stall_cnt),
    .flush_cnt   (flush_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_ifid(input string tag, input logic [31:0] instr,
                            input logic [31:0] pc4, input logic valid);
    check({tag, ".instr"}, ifid_instr, instr);
    check({tag, ".pc4"},   ifid_pc4,   pc4);
    check({tag, ".valid"}, {31'd0, ifid_valid}, {31'd0, valid});
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, ".addr"}, imem_addr, 32'h0040_0000);
    check_ifid(tag, 32'h0, 32'h0, 1'b0);
    check({tag, ".scnt"}, {16'd0, stall_cnt}, 32'd0);
    check({tag, ".fcnt"}, {16'd0, flush_cnt}, 32'd0);
  endtask

  initial begin
    rst_n       = 1'b0;
    stall       = 1'b0;
    flush       = 1'b0;
    redirect_pc = 32'h0;
    imem_rdy    = 1'b1;
    imem_instr  = 32'h2008_0001;

    #23;
    check_reset_state("rst_held");
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    // sequential fetch from RESET_PC
    check("seq0.addr", imem_addr, 32'h0040_0000);
    step();
    check_ifid("seq0", 32'h2008_0001, 32'h0040_0004, 1'b1);
    check("seq1.addr", imem_addr, 32'h0040_0004);
    imem_instr = 32'h2009_0002;
    step();
    check_ifid("seq1", 32'h2009_0002, 32'h0040_0008, 1'b1);
    imem_instr = 32'h8D28_0000;
    step();
    check_ifid("seq2", 32'h8D28_0000, 32'h0040_000C, 1'b1);

    // three-cycle stall: everything frozen, memory data ignored
    stall      = 1'b1;
    imem_instr = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      step();
      check_ifid("stall", 32'h8D28_0000, 32'h0040_000C, 1'b1);
      check("stall.addr", imem_addr, 32'h0040_000C);
    end
    check("stall.scnt", {16'd0, stall_cnt}, 32'd3);
    stall      = 1'b0;
    imem_instr = 32'h1111_1111;
    step();
    check_ifid("resume", 32'h1111_1111, 32'h0040_0010, 1'b1);
    check("resume.addr", imem_addr, 32'h0040_0010);

    // flush with unaligned target: one bubble, then redirected fetch
    flush       = 1'b1;
    redirect_pc = 32'h0040_0103;
    step();
    check_ifid("flush", 32'h0, 32'h0, 1'b0);
    check("flush.addr", imem_addr, 32'h0040_0100);
    check("flush.fcnt", {16'd0, flush_cnt}, 32'd1);
    flush      = 1'b0;
    imem_instr = 32'h2222_2222;
    step();
    check_ifid("redir", 32'h2222_2222, 32'h0040_0104, 1'b1);

    // stall and flush together: stall wins
    stall       = 1'b1;
    flush       = 1'b1;
    redirect_pc = 32'h0040_0200;
    step();
    check("sf.addr", imem_addr, 32'h0040_0104);
    check("sf.fcnt", {16'd0, flush_cnt}, 32'd1);
    check("sf.scnt", {16'd0, stall_cnt}, 32'd4);
    check_ifid("sf", 32'h2222_2222, 32'h0040_0104, 1'b1);
    stall = 1'b0;
    flush = 1'b0;

    // memory not ready: bubbles, PC held
    imem_rdy = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      check_ifid("nrdy", 32'h0, 32'h0, 1'b0);
      check("nrdy.addr", imem_addr, 32'h0040_0104);
    end
    imem_rdy   = 1'b1;
    imem_instr = 32'h3333_3333;
    step();
    check_ifid("rdy", 32'h3333_3333, 32'h0040_0108, 1'b1);

    // flush while not ready still redirects
    imem_rdy    = 1'b0;
    flush       = 1'b1;
    redirect_pc = 32'h0040_0300;
    step();
    check("fnr.addr", imem_addr, 32'h0040_0300);
    check("fnr.fcnt", {16'd0, flush_cnt}, 32'd2);
    check_ifid("fnr", 32'h0, 32'h0, 1'b0);
    imem_rdy = 1'b1;

    // PC wrap at the top of the address space
    redirect_pc = 32'hFFFF_FFFF;
    step();
    check("wrap.addr0", imem_addr, 32'hFFFF_FFFC);
    flush      = 1'b0;
    imem_instr = 32'h4444_4444;
    step();
    check_ifid("wrap", 32'h4444_4444, 32'h0, 1'b1);
    check("wrap.addr1", imem_addr, 32'h0);

    // asynchronous reset in the middle of a stall with a pending flush
    stall       = 1'b1;
    flush       = 1'b1;
    redirect_pc = 32'h0050_0000;
    step();
    check("prerst.scnt", {16'd0, stall_cnt}, 32'd5);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_state("async_rst");
    stall = 1'b0;
    flush = 1'b0;
    imem_instr = 32'h5555_5555;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check_ifid("postrst", 32'h5555_5555, 32'h0040_0004, 1'b1);

    // counter saturation: 2^16 + 5 stall cycles
    stall = 1'b1;
    repeat (65536 + 5) @(posedge clk);
    #1;
    check("sat.scnt", {16'd0, stall_cnt}, 32'h0000_FFFF);
    check("sat.fcnt", {16'd0, flush_cnt}, 32'd0);
    check_ifid("sat", 32'h5555_5555, 32'h0040_0004, 1'b1);
    stall = 1'b0;
    step();
    check("sat.hold", {16'd0, stall_cnt}, 32'h0000_FFFF);

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
